// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM of the multicycle MIPS core. It sequences each
//   instruction through fetch, decode, execute, memory and writeback. It
//   decodes the opcode, drives the datapath mux selects and write enables,
//   and supplies ALUOp to the ALU control decoder.
//   Memory accesses handshake on mem_ready. A wait counter bounds how long
//   the FSM may stall in a memory state. When the bound is exceeded the FSM
//   parks in HALT and raises the sticky mem_err flag.
//
// Parameters
//   MEM_TIMEOUT  consecutive not-ready cycles in a memory state before the
//                FSM halts (0 disables the timeout)
//   CNT_W        width of instr_count
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   opcode[5:0]         IR[31:26], valid from DECODE onward
//   mem_ready           memory completes the current access this cycle
//   PCWrite             unconditional PC load
//   PCWriteCond         PC load if ALU zero (beq)
//   PCWriteCondNe       PC load if ALU not zero (bne)
//   IorD                memory address select: 0 = PC, 1 = ALUOut
//   MemRead, MemWrite   memory request strobes
//   IRWrite             instruction register load
//   MemtoReg            write-back source: 1 = MDR, 0 = ALUOut
//   RegDst              write register select: 1 = rd, 0 = rt
//   RegWrite            register file write enable
//   ALUSrcA             0 = PC, 1 = reg A
//   ALUSrcB[1:0]        00 = B, 01 = 4, 10 = ext imm, 11 = ext imm << 2
//   ZeroExt             1 = zero-extend immediate (andi)
//   ALUOp[2:0]          000 add, 001 sub, 010 funct, 011 addi, 100 andi
//   PCSource[1:0]       00 = ALU result, 01 = ALUOut, 10 = jump target
//   illegal_op          one-cycle pulse on an unknown opcode
//   mem_err             sticky memory-timeout flag
//   instr_count         retired instruction count (wraps)
//   state[3:0]          current FSM state (debug)
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCWriteCondNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ZeroExt,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ANDIEX  = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13,
    S_HALT    = 4'd14,
    S_RESET   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // The counter only ever holds 0..MEM_TIMEOUT-1: the cycle that would reach
  // MEM_TIMEOUT leaves for HALT instead of incrementing.
  localparam int unsigned       WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               mem_state;
  logic               retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      wait_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    count_d       = count_q;
    err_d         = err_q;
    mem_state     = 1'b0;
    retire        = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ZeroExt       = 1'b0;
    ALUOp         = 3'b000;
    PCSource      = 2'b00;
    illegal_op    = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        mem_state = 1'b1;
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_ANDI:        state_d = S_ANDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_ILLEGAL;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_state = 1'b1;
        MemRead   = 1'b1;
        IorD      = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWR: begin
        mem_state = 1'b1;
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 3'b001;
        PCSource      = 2'b01;
        PCWriteCond   = (opcode == OP_BEQ);
        PCWriteCondNe = (opcode == OP_BNE);
        retire        = 1'b1;
        state_d       = S_FETCH;
      end

      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 3'b011;
        state_d = S_IMMWB;
      end

      S_ANDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 3'b100;
        ZeroExt = 1'b1;
        state_d = S_IMMWB;
      end

      S_IMMWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_ILLEGAL: begin
        illegal_op = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_RESET;
    endcase

    // Stall accounting for memory states. A ready cycle leaves the counter at
    // zero (default), so mem_ready on the final allowed cycle beats timeout.
    if (mem_state && !mem_ready) begin
      if ((MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    if (retire) count_d = count_q + 1'b1;
  end

  assign state       = state_q;
  assign mem_err     = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
  logic          IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt;
  logic [1:0]    ALUSrcB, PCSource;
  logic [2:0]    ALUOp;
  logic          illegal_op, mem_err;
  logic [CW-1:0] instr_count;
  logic [3:0]    state;
  logic [19:0]   ctrl_bus;

  int n_vec = 0;
  int n_err = 0;
  int m_count = 0;
  int m_err = 0;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt), .ALUOp(ALUOp), .PCSource(PCSource),
    .illegal_op(illegal_op), .mem_err(mem_err), .instr_count(instr_count),
    .state(state)
  );

  always #5 clk = ~clk;

  assign ctrl_bus = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
                     IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ZeroExt,
                     ALUOp, PCSource, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Control outputs each state should present, straight from the state table.
  function automatic logic [19:0] exp_ctrl(input int st, input logic rdy, input logic [5:0] op);
    logic pcw, pcwc, pcwne, iord, mr, mw, irw, m2r, rdst, rw, asa, zx, ill;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, pcwne, iord, mr, mw, irw, m2r, rdst, rw, asa, zx, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mr = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; iord = 1'b1; end
      6:  begin asa = 1'b1; aop = 3'b010; end
      7:  begin rw = 1'b1; rdst = 1'b1; end
      8:  begin asa = 1'b1; aop = 3'b001; pcs = 2'b01;
                pcwc = (op == 6'b000100); pcwne = (op == 6'b000101); end
      9:  begin asa = 1'b1; asb = 2'b10; aop = 3'b011; end
      10: begin asa = 1'b1; asb = 2'b10; aop = 3'b100; zx = 1'b1; end
      11: rw = 1'b1;
      12: begin pcw = 1'b1; pcs = 2'b10; end
      13: ill = 1'b1;
      default: ;
    endcase
    return {pcw, pcwc, pcwne, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, zx, aop, pcs, ill};
  endfunction

  // One clock cycle: drive inputs mid-cycle, check everything, cross the edge.
  task automatic step(input int st, input logic rdy, input logic [5:0] op);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    #1;
    check("state", {28'd0, state}, st);
    check("ctrl", {12'd0, ctrl_bus}, exp_ctrl(st, rdy, op));
    check("count", {28'd0, instr_count}, m_count);
    check("mem_err", {31'd0, mem_err}, m_err);
    @(posedge clk);
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic retire_one();
    m_count = (m_count + 1) % (1 << CW);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_state", {28'd0, state}, 15);
    check("rst_ctrl", {12'd0, ctrl_bus}, 0);
    check("rst_count", {28'd0, instr_count}, 0);
    check("rst_err", {31'd0, mem_err}, 0);
    m_count = 0;
    m_err   = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(15, rnd_bit(), rnd_op());
  endtask

  // Expected per-instruction state trace, given fetch and memory stall lengths.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(0, 1'b0, rnd_op());
    step(0, 1'b1, rnd_op());
    step(1, rnd_bit(), op);
    case (op)
      6'b100011: begin
        step(2, rnd_bit(), op);
        for (int i = 0; i < mw; i++) step(3, 1'b0, op);
        step(3, 1'b1, op);
        step(4, rnd_bit(), op);
        retire_one();
      end
      6'b101011: begin
        step(2, rnd_bit(), op);
        for (int i = 0; i < mw; i++) step(5, 1'b0, op);
        step(5, 1'b1, op);
        retire_one();
      end
      6'b000000: begin step(6, rnd_bit(), op); step(7, rnd_bit(), op); retire_one(); end
      6'b000100, 6'b000101: begin step(8, rnd_bit(), op); retire_one(); end
      6'b001000: begin step(9, rnd_bit(), op); step(11, rnd_bit(), op); retire_one(); end
      6'b001100: begin step(10, rnd_bit(), op); step(11, rnd_bit(), op); retire_one(); end
      6'b000010: begin step(12, rnd_bit(), op); retire_one(); end
      default:   step(13, rnd_bit(), op);
    endcase
  endtask

  // Stall past the limit either in FETCH or in the store's MEMWR state.
  task automatic run_timeout(input bit in_fetch);
    if (in_fetch) begin
      for (int i = 0; i < int'(TO); i++) step(0, 1'b0, rnd_op());
    end else begin
      step(0, 1'b1, rnd_op());
      step(1, rnd_bit(), 6'b101011);
      step(2, rnd_bit(), 6'b101011);
      for (int i = 0; i < int'(TO); i++) step(5, 1'b0, 6'b101011);
    end
    m_err = 1;
    for (int i = 0; i < 3; i++) step(14, rnd_bit(), rnd_op());
    do_reset();
  endtask

  logic [5:0] op_tab [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b000101, 6'b001000, 6'b001100, 6'b000010};

  initial begin
    rst_n = 1'b1;
    mem_ready = 1'b0;
    opcode = '0;
    #3 rst_n = 1'b0;
    do_reset();

    run_instr(6'b100011, 2, 1);   // lw with fetch and read stalls
    run_instr(6'b000000, 0, 0);   // R-type
    run_instr(6'b000100, 0, 0);   // beq
    run_instr(6'b000101, 1, 0);   // bne
    run_instr(6'b001100, 0, 0);   // andi
    run_instr(6'b001000, 0, 0);   // addi
    run_instr(6'b111111, 0, 0);   // illegal
    run_instr(6'b000010, 0, 0);   // jump
    run_instr(6'b101011, int'(TO) - 1, int'(TO) - 1); // ready on the last allowed cycle

    for (int n = 0; n < 60; n++) begin
      int unsigned k = $urandom_range(0, 9);
      logic [5:0] op = (k < 8) ? op_tab[k] : rnd_op();
      run_instr(op, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end

    run_timeout(1'b0);
    run_instr(6'b000000, 0, 0);
    run_timeout(1'b1);

    // Reset while a store is stalled: the write strobe must drop immediately.
    step(0, 1'b1, rnd_op());
    step(1, 1'b0, 6'b101011);
    step(2, 1'b0, 6'b101011);
    step(5, 1'b0, 6'b101011);
    do_reset();
    run_instr(6'b100011, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
